multicycle_main_fsm: RTL and testbench
======================================

# multicycle_main_fsm

Main control state machine for the multicycle ARM core of the calculator. It walks each instruction through fetch, decode, execute, memory and writeback. It drives the datapath multiplexer selects and write enables, and sets `ALUOp` for the downstream ALU decoder, which turns `Funct` into `ALUControl` and `FlagW`. Conditional-execution gating of `RegW`, `MemW` and `Branch` is handled after this block and is out of scope.

## Interface
Parameters:
- none; the state encoding is a fixed 4-bit localparam set.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; forces state to FETCH.
- `Op`  in  2  Instr[27:26]: 00 data-processing, 01 memory, 10 branch, 11 illegal.
- `I`  in  1  Instr[25]: immediate operand select.
- `Funct`  in  5  Instr[24:20]: {cmd[3:0], S/L}. Funct[0] is the L bit for memory instructions.
- `MemReady`  in  1  memory handshake. Present only with `MAIN_FSM_STALL_EN`.
- `IRWrite`  out  1  instruction register load.
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = ALU result.
- `ALUSrcA`  out  1  ALU A operand: 0 = Rn, 1 = PC.
- `ALUSrcB`  out  2  ALU B operand: 00 = Rm, 01 = ExtImm, 10 = constant 4.
- `ResultSrc`  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `NextPC`  out  1  PC write, unconditional.
- `RegW`  out  1  register file write, before condition gating.
- `MemW`  out  1  memory write, before condition gating.
- `Branch`  out  1  branch request, before condition gating.
- `ALUOp`  out  1  1 = decode `Funct` (data-processing); 0 = force add.
- `IllegalOp`  out  1  one-cycle pulse in DECODE when `Op` = 11.

## Operation
- Moore FSM. All outputs are a pure function of the state register. Any output not listed for a state is 0.
- FETCH: `IRWrite`=1, `NextPC`=1, `AdrSrc`=0, `ALUSrcA`=1, `ALUSrcB`=10, `ResultSrc`=10. Next state is always DECODE.
- DECODE: `ALUSrcA`=1, `ALUSrcB`=10, `ResultSrc`=10 (computes PC+8). Next state:
  - `Op`=00, `I`=0 → EXECUTER
  - `Op`=00, `I`=1 → EXECUTEI
  - `Op`=01 → MEMADR
  - `Op`=10 → BRANCH
  - `Op`=11 → FETCH, with `IllegalOp`=1
- EXECUTER: `ALUSrcA`=0, `ALUSrcB`=00, `ALUOp`=1.
- EXECUTEI: `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=1.
- Leaving EXECUTER or EXECUTEI:
  - `Funct[4:1]`=1010 (CMP) → FETCH. No writeback is performed.
  - otherwise → ALUWB.
- ALUWB: `ResultSrc`=00, `RegW`=1. Next state is FETCH.
- MEMADR: `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=0. Next state is MEMREAD if `Funct[0]`=1, otherwise MEMWRITE.
- MEMREAD: `AdrSrc`=1, `ResultSrc`=00. Next state is MEMWB.
- MEMWB: `ResultSrc`=01, `RegW`=1. Next state is FETCH.
- MEMWRITE: `AdrSrc`=1, `ResultSrc`=00, `MemW`=1. Next state is FETCH.
- BRANCH: `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=0, `ResultSrc`=10, `Branch`=1. Next state is FETCH.
- Reset behaviour:
  - While `reset`=1, every output is forced to 0 combinationally, so no PC or IR write happens during reset.
  - The state register loads FETCH on each edge where `reset`=1.
  - Reset mid-instruction abandons the instruction. No write enable asserts in the cycle that reset is sampled.
- Unused state encodings go to FETCH on the next edge, with all outputs 0 while in them.
- `Op`, `I` and `Funct` are sampled only in the states named above. Changes at any other time have no effect.

## Timing
- Instruction latency in cycles, counting from the FETCH cycle up to the next FETCH:
  - data-processing: 4
  - CMP: 3
  - LDR: 5
  - STR: 4
  - B: 3
  - illegal: 2
- `IllegalOp` is high for exactly the single DECODE cycle.
- With `MAIN_FSM_STALL_EN` defined, each of the following holds state until `MemReady` is sampled 1, with outputs held constant meanwhile:
  - FETCH
  - MEMREAD
  - MEMWRITE
- Under stall, `IRWrite`, `NextPC` and `MemW` are qualified by `MemReady`. They assert only in the cycle `MemReady`=1, so each fires exactly once.

## Configuration
- Macro: `MAIN_FSM_STALL_EN`.
- Defined: the `MemReady` port exists and the stall behaviour above applies.
- Undefined: the port is absent, memory is single-cycle, and every state lasts exactly one cycle.

## Test plan
- Reset: hold `reset`=1 for 3 cycles, then release. All outputs are 0 during reset. The first cycle after release is FETCH, with `IRWrite`=1, `NextPC`=1 and `ALUSrcB`=10.
- ADD register: `Op`=00, `I`=0, `Funct`=01000. Sequence is FETCH, DECODE, EXECUTER, ALUWB. `ALUOp`=1 only in EXECUTER, `RegW`=1 only in ALUWB, then back to FETCH.
- CMP immediate then illegal op:
  - `Op`=00, `I`=1, `Funct`=10101 → FETCH, DECODE, EXECUTEI, FETCH. `RegW` is never 1.
  - then `Op`=11 → `IllegalOp` pulses once in DECODE, then FETCH.
- LDR then STR:
  - `Op`=01, `Funct[0]`=1 → 5 cycles, with `ResultSrc`=01 and `RegW`=1 in MEMWB.
  - `Op`=01, `Funct[0]`=0 → 4 cycles, with `MemW`=1 for exactly 1 cycle.
- Branch plus reset abort:
  - `Op`=10 → `Branch`=1 in the third cycle.
  - separately, assert `reset` during MEMWB → `RegW` stays 0 and the state returns to FETCH.
- Stall (with `MAIN_FSM_STALL_EN`): LDR with `MemReady`=0 for 2 cycles in FETCH and 3 cycles in MEMREAD.
  - Total is 10 cycles.
  - `IRWrite` and `NextPC` each assert exactly once.

Source files
------------

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multicycle ARM core: fetch/decode/execute/memory/writeback sequencing.
// Optional macro MAIN_FSM_STALL_EN adds MemReady and stalls FETCH, MEMREAD and MEMWRITE until it is high.
module multicycle_main_fsm (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] Op,
   input  logic       I,
   input  logic [4:0] Funct,
`ifdef MAIN_FSM_STALL_EN
   input  logic       MemReady,
`endif
   output logic       IRWrite,
   output logic       AdrSrc,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic       NextPC,
   output logic       RegW,
   output logic       MemW,
   output logic       Branch,
   output logic       ALUOp,
   output logic       IllegalOp
);

   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEMADR   = 4'd2;
   localparam logic [3:0] S_MEMREAD  = 4'd3;
   localparam logic [3:0] S_MEMWB    = 4'd4;
   localparam logic [3:0] S_MEMWRITE = 4'd5;
   localparam logic [3:0] S_EXECUTER = 4'd6;
   localparam logic [3:0] S_EXECUTEI = 4'd7;
   localparam logic [3:0] S_ALUWB    = 4'd8;
   localparam logic [3:0] S_BRANCH   = 4'd9;

   localparam logic [3:0] CMD_CMP    = 4'b1010;

   logic [3:0] state_q;
   logic [3:0] state_d;
   logic       mem_rdy;

`ifdef MAIN_FSM_STALL_EN
   assign mem_rdy = MemReady;
`else
   assign mem_rdy = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:    state_d = mem_rdy ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (Op)
               2'b00:   state_d = I ? S_EXECUTEI : S_EXECUTER;
               2'b01:   state_d = S_MEMADR;
               2'b10:   state_d = S_BRANCH;
               default: state_d = S_FETCH;
            endcase
         end
         // Compares only update flags, so they skip the writeback state.
         S_EXECUTER,
         S_EXECUTEI: state_d = (Funct[4:1] == CMD_CMP) ? S_FETCH : S_ALUWB;
         S_MEMADR:   state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_d = mem_rdy ? S_MEMWB : S_MEMREAD;
         S_MEMWRITE: state_d = mem_rdy ? S_FETCH : S_MEMWRITE;
         S_MEMWB,
         S_ALUWB,
         S_BRANCH:   state_d = S_FETCH;
         default:    state_d = S_FETCH;
      endcase
   end

   always_comb begin
      IRWrite   = 1'b0;
      AdrSrc    = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 2'b00;
      ResultSrc = 2'b00;
      NextPC    = 1'b0;
      RegW      = 1'b0;
      MemW      = 1'b0;
      Branch    = 1'b0;
      ALUOp     = 1'b0;
      IllegalOp = 1'b0;
      // Reset masks everything so no PC/IR/register/memory write escapes while it is held.
      if (!reset) begin
         case (state_q)
            S_FETCH: begin
               IRWrite   = mem_rdy;
               NextPC    = mem_rdy;
               ALUSrcA   = 1'b1;
               ALUSrcB   = 2'b10;
               ResultSrc = 2'b10;
            end
            S_DECODE: begin
               ALUSrcA   = 1'b1;
               ALUSrcB   = 2'b10;
               ResultSrc = 2'b10;
               IllegalOp = (Op == 2'b11);
            end
            S_EXECUTER: begin
               ALUSrcB = 2'b00;
               ALUOp   = 1'b1;
            end
            S_EXECUTEI: begin
               ALUSrcB = 2'b01;
               ALUOp   = 1'b1;
            end
            S_ALUWB: begin
               ResultSrc = 2'b00;
               RegW      = 1'b1;
            end
            S_MEMADR: begin
               ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
               AdrSrc = 1'b1;
            end
            S_MEMWB: begin
               ResultSrc = 2'b01;
               RegW      = 1'b1;
            end
            S_MEMWRITE: begin
               AdrSrc = 1'b1;
               MemW   = mem_rdy;
            end
            S_BRANCH: begin
               ALUSrcB   = 2'b01;
               ResultSrc = 2'b10;
               Branch    = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Self-checking bench for multicycle_main_fsm: directed scenarios plus randomized instructions
// against a per-instruction phase-sequence model.
module tb_multicycle_main_fsm;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] Op;
   logic       I;
   logic [4:0] Funct;
`ifdef MAIN_FSM_STALL_EN
   logic       MemReady;
`endif
   logic       IRWrite, AdrSrc, ALUSrcA, NextPC, RegW, MemW, Branch, ALUOp, IllegalOp;
   logic [1:0] ALUSrcB, ResultSrc;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   multicycle_main_fsm dut (
      .clk       (clk),
      .reset     (reset),
      .Op        (Op),
      .I         (I),
      .Funct     (Funct),
`ifdef MAIN_FSM_STALL_EN
      .MemReady  (MemReady),
`endif
      .IRWrite   (IRWrite),
      .AdrSrc    (AdrSrc),
      .ALUSrcA   (ALUSrcA),
      .ALUSrcB   (ALUSrcB),
      .ResultSrc (ResultSrc),
      .NextPC    (NextPC),
      .RegW      (RegW),
      .MemW      (MemW),
      .Branch    (Branch),
      .ALUOp     (ALUOp),
      .IllegalOp (IllegalOp)
   );

   // {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW, Branch, ALUOp, IllegalOp}
   logic [12:0] got;
   assign got = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW, Branch, ALUOp, IllegalOp};

   localparam logic [12:0] E_FETCH  = {1'b1, 1'b0, 1'b1, 2'b10, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam logic [12:0] E_FSTALL = {1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam logic [12:0] E_DECODE = {1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam logic [12:0] E_ILLDEC = {1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   localparam logic [12:0] E_EXR    = {1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
   localparam logic [12:0] E_EXI    = {1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
   localparam logic [12:0] E_ALUWB  = {1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam logic [12:0] E_MEMADR = {1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam logic [12:0] E_MEMRD  = {1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam logic [12:0] E_MEMWB  = {1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam logic [12:0] E_MEMWR  = {1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
   localparam logic [12:0] E_BRANCH = {1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

   // Reference model: the list of per-cycle output words one instruction produces.
   logic [12:0] exp_q[$];

   function automatic void build_seq(input logic [1:0] op, input logic ii, input logic [4:0] f);
      exp_q.delete();
      exp_q.push_back(E_FETCH);
      exp_q.push_back(op == 2'b11 ? E_ILLDEC : E_DECODE);
      case (op)
         2'b00: begin
            exp_q.push_back(ii ? E_EXI : E_EXR);
            if (f[4:1] != 4'b1010) exp_q.push_back(E_ALUWB);
         end
         2'b01: begin
            exp_q.push_back(E_MEMADR);
            if (f[0]) begin
               exp_q.push_back(E_MEMRD);
               exp_q.push_back(E_MEMWB);
            end else begin
               exp_q.push_back(E_MEMWR);
            end
         end
         2'b10: exp_q.push_back(E_BRANCH);
         default: ;
      endcase
   endfunction

   // Instruction fields are only meaningful in cycles 1 and 2; elsewhere they carry noise.
   task automatic cycle(input logic [1:0] op, input logic ii, input logic [4:0] f,
                        input bit valid, output logic [12:0] obs);
      if (valid) begin
         Op = op; I = ii; Funct = f;
      end else begin
         Op = 2'($urandom); I = 1'($urandom); Funct = 5'($urandom);
      end
      @(negedge clk);
      obs = got;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         Op = 2'($urandom); I = 1'($urandom); Funct = 5'($urandom);
         @(negedge clk);
         tests++;
         if (got !== 13'h0) begin
            fails++;
            $display("FAIL reset_outputs cycle %0d: got %h expected %h", c, got, 13'h0);
         end
         @(posedge clk);
      end
      #1 reset = 1'b0;
      #3;
      tests++;
      if (got !== E_FETCH) begin
         fails++;
         $display("FAIL reset_first_fetch: got %h expected %h", got, E_FETCH);
      end
   endtask

   task automatic test_add();
      logic [12:0] obs;
      build_seq(2'b00, 1'b0, 5'b01000);
      for (int k = 0; k < exp_q.size(); k++) begin
         cycle(2'b00, 1'b0, 5'b01000, (k == 1 || k == 2), obs);
         tests++;
         if (obs !== exp_q[k]) begin
            fails++;
            $display("FAIL add_reg cycle %0d: got %h expected %h", k, obs, exp_q[k]);
         end
      end
   endtask

   task automatic test_cmp_illegal();
      logic [12:0] obs;
      int regw_cnt, ill_cnt;
      regw_cnt = 0;
      build_seq(2'b00, 1'b1, 5'b10101);
      for (int k = 0; k < exp_q.size(); k++) begin
         cycle(2'b00, 1'b1, 5'b10101, (k == 1 || k == 2), obs);
         regw_cnt += int'(obs[4]);
         tests++;
         if (obs !== exp_q[k]) begin
            fails++;
            $display("FAIL cmp_imm cycle %0d: got %h expected %h", k, obs, exp_q[k]);
         end
      end
      tests++;
      if (regw_cnt != 0) begin
         fails++;
         $display("FAIL cmp_no_regw: got %0d RegW cycles expected 0", regw_cnt);
      end
      ill_cnt = 0;
      build_seq(2'b11, 1'b0, 5'b00000);
      for (int k = 0; k < exp_q.size(); k++) begin
         cycle(2'b11, 1'b0, 5'b00000, (k == 1), obs);
         ill_cnt += int'(obs[0]);
         tests++;
         if (obs !== exp_q[k]) begin
            fails++;
            $display("FAIL illegal cycle %0d: got %h expected %h", k, obs, exp_q[k]);
         end
      end
      tests++;
      if (ill_cnt != 1) begin
         fails++;
         $display("FAIL illegal_pulse: got %0d cycles expected 1", ill_cnt);
      end
   endtask

   task automatic test_ldr_str();
      logic [12:0] obs;
      int memw_cnt;
      build_seq(2'b01, 1'b1, 5'b11001);
      for (int k = 0; k < exp_q.size(); k++) begin
         cycle(2'b01, 1'b1, 5'b11001, (k == 1 || k == 2), obs);
         tests++;
         if (obs !== exp_q[k]) begin
            fails++;
            $display("FAIL ldr cycle %0d: got %h expected %h", k, obs, exp_q[k]);
         end
      end
      memw_cnt = 0;
      build_seq(2'b01, 1'b0, 5'b11000);
      for (int k = 0; k < exp_q.size(); k++) begin
         cycle(2'b01, 1'b0, 5'b11000, (k == 1 || k == 2), obs);
         memw_cnt += int'(obs[3]);
         tests++;
         if (obs !== exp_q[k]) begin
            fails++;
            $display("FAIL str cycle %0d: got %h expected %h", k, obs, exp_q[k]);
         end
      end
      tests++;
      if (memw_cnt != 1) begin
         fails++;
         $display("FAIL str_memw_once: got %0d cycles expected 1", memw_cnt);
      end
   endtask

   task automatic test_branch_reset_abort();
      logic [12:0] obs;
      build_seq(2'b10, 1'b0, 5'b00000);
      for (int k = 0; k < exp_q.size(); k++) begin
         cycle(2'b10, 1'b0, 5'b00000, (k == 1), obs);
         tests++;
         if (obs !== exp_q[k] || (k == 2 && obs[2] !== 1'b1)) begin
            fails++;
            $display("FAIL branch cycle %0d: got %h expected %h", k, obs, exp_q[k]);
         end
      end
      // LDR interrupted by reset while in MEMWB (cycle 4)
      for (int k = 0; k < 4; k++) cycle(2'b01, 1'b0, 5'b00001, (k == 1 || k == 2), obs);
      reset = 1'b1;
      @(negedge clk);
      tests++;
      if (RegW !== 1'b0 || got !== 13'h0) begin
         fails++;
         $display("FAIL abort_memwb: got %h (RegW %b) expected %h", got, RegW, 13'h0);
      end
      @(posedge clk);
      #1 reset = 1'b0;
      #3;
      tests++;
      if (got !== E_FETCH) begin
         fails++;
         $display("FAIL abort_return_fetch: got %h expected %h", got, E_FETCH);
      end
   endtask

   task automatic test_random();
      logic [12:0] obs;
      logic [1:0]  op;
      logic        ii;
      logic [4:0]  f;
      int          abort_at;
      for (int n = 0; n < 150; n++) begin
         op = 2'($urandom); ii = 1'($urandom); f = 5'($urandom);
         if ($urandom_range(3, 0) == 0) f[4:1] = 4'b1010;
         build_seq(op, ii, f);
         abort_at = ($urandom_range(3, 0) == 0) ? int'($urandom_range(exp_q.size() - 1, 1)) : -1;
         for (int k = 0; k < exp_q.size(); k++) begin
            if (k == abort_at) begin
               reset = 1'b1;
               Op = 2'($urandom); I = 1'($urandom); Funct = 5'($urandom);
               @(negedge clk);
               tests++;
               if (got !== 13'h0) begin
                  fails++;
                  $display("FAIL rand_abort n%0d k%0d: got %h expected %h", n, k, got, 13'h0);
               end
               @(posedge clk);
               #1 reset = 1'b0;
               break;
            end
            cycle(op, ii, f, (k == 1 || k == 2), obs);
            tests++;
            if (obs !== exp_q[k]) begin
               fails++;
               $display("FAIL rand n%0d op%b i%b f%b cycle %0d: got %h expected %h",
                        n, op, ii, f, k, obs, exp_q[k]);
            end
         end
      end
   endtask

`ifdef MAIN_FSM_STALL_EN
   task automatic test_stall();
      logic [12:0] obs;
      logic [12:0] exp_s[10];
      bit          rdy[10];
      int          irw_cnt, npc_cnt;
      exp_s = '{E_FSTALL, E_FSTALL, E_FETCH, E_DECODE, E_MEMADR,
                E_MEMRD, E_MEMRD, E_MEMRD, E_MEMRD, E_MEMWB};
      rdy   = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 1};
      irw_cnt = 0; npc_cnt = 0;
      for (int k = 0; k < 10; k++) begin
         MemReady = rdy[k];
         cycle(2'b01, 1'b0, 5'b00001, (k == 3 || k == 4), obs);
         irw_cnt += int'(obs[12]);
         npc_cnt += int'(obs[5]);
         tests++;
         if (obs !== exp_s[k]) begin
            fails++;
            $display("FAIL stall_ldr cycle %0d: got %h expected %h", k, obs, exp_s[k]);
         end
      end
      MemReady = 1'b1;
      tests++;
      if (irw_cnt != 1 || npc_cnt != 1) begin
         fails++;
         $display("FAIL stall_once: got IRWrite %0d NextPC %0d expected 1 1", irw_cnt, npc_cnt);
      end
      #3;
      tests++;
      if (got !== E_FETCH) begin
         fails++;
         $display("FAIL stall_return_fetch: got %h expected %h", got, E_FETCH);
      end
   endtask
`endif

   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; Op = 2'b00; I = 1'b0; Funct = 5'b00000;
`ifdef MAIN_FSM_STALL_EN
      MemReady = 1'b1;
`endif
      test_reset();
      test_add();
      test_cmp_illegal();
      test_ldr_str();
      test_branch_reset_abort();
`ifdef MAIN_FSM_STALL_EN
      test_stall();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
